// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry, write-back requester indices and
// the write-port record used by the write-back arbiter and its bench.
package regfile_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int WB_NREQ        = 3;

    // Fixed requester slots on the write-back arbiter
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_CSR  = 2;

    // x0 is hard-wired to zero; writes to it are consumed but never land
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

    // One registered write-port transaction at the default geometry
    typedef struct packed {
        logic                      we;
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [REG_DATA_WIDTH-1:0] data;
    } wb_write_t;

endpackage : regfile_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, rotating priority pointer.
// The requester at the pointer has highest priority; after a grant to i the
// pointer moves to i+1 (mod N). With no grant, or with en low, it holds.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW  = (N > 1) ? $clog2(N) : 1;
    localparam int PW1 = PW + 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_gnt_idx;
    logic          w_any;

    // Scan requesters from the pointer upward, wrapping, and grant the first valid one
    always_comb begin
        logic [PW1-1:0] w_idx;
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        gnt       = '0;
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr} + PW1'(k);
            if (w_idx >= PW1'(N)) begin
                w_idx = w_idx - PW1'(N);
            end
            if (en && !w_any && req[w_idx[PW-1:0]]) begin
                gnt[w_idx[PW-1:0]] = 1'b1;
                w_any              = 1'b1;
                w_gnt_idx          = w_idx[PW-1:0];
            end
        end
    end

    // Advance the pointer past the winner; hold it when nothing was granted
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_gnt_idx == PW'(N - 1)) ? '0 : w_gnt_idx + PW'(1);
        end
    end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and sequencer for the register file's single write port.
// NREQ producers compete through a round-robin arbiter; the winner is
// registered onto we3/a3/wd3 one cycle after the grant. Writes to x0 are
// consumed but keep we3 low.
// Optional feature macro: WB_ARB_BYPASS_EN -- forwards the in-flight
// registered write to rd1/rd2; when undefined rd1/rd2 are pure pass-through.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ       = WB_NREQ,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       we3,
    output logic [ADDR_WIDTH-1:0]      a3,
    output logic [DATA_WIDTH-1:0]      wd3,
    input  logic [ADDR_WIDTH-1:0]      ra1,
    input  logic [ADDR_WIDTH-1:0]      ra2,
    input  logic [DATA_WIDTH-1:0]      rf_rd1,
    input  logic [DATA_WIDTH-1:0]      rf_rd2,
    output logic [DATA_WIDTH-1:0]      rd1,
    output logic [DATA_WIDTH-1:0]      rd2
);

    logic [NREQ-1:0]       w_gnt;
    logic                  w_arb_en;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_d;

    // No grants during flush, and none while reset is held
    assign w_arb_en = rst_n & ~flush;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (w_arb_en),
        .gnt   (w_gnt)
    );

    assign req_ready = w_gnt;

    // One-hot AND-OR mux picks the granted requester's address and data
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr |= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data |= req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Register the winning write; x0 targets and idle cycles leave we3 low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we <= 1'b0;
            r_a  <= '0;
            r_d  <= '0;
        end else if (|w_gnt) begin
            r_we <= (w_sel_addr != ADDR_WIDTH'(REG_ZERO));
            r_a  <= w_sel_addr;
            r_d  <= w_sel_data;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign we3 = r_we;
    assign a3  = r_a;
    assign wd3 = r_d;

`ifdef WB_ARB_BYPASS_EN
    // The registered write lands at the next edge; forward it to matching readers now
    assign rd1 = (r_we && (r_a == ra1) && (ra1 != ADDR_WIDTH'(REG_ZERO))) ? r_d : rf_rd1;
    assign rd2 = (r_we && (r_a == ra2) && (ra2 != ADDR_WIDTH'(REG_ZERO))) ? r_d : rf_rd2;
`else
    logic w_unused_ra;

    assign rd1         = rf_rd1;
    assign rd2         = rf_rd2;
    assign w_unused_ra = ^{ra1, ra2};
`endif

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a round-robin reference model predicts
// req_ready each cycle and pushes the expected write-port value to a
// scoreboard queue, which is popped and compared one cycle later.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = WB_NREQ;
    localparam int AW   = REG_ADDR_WIDTH;
    localparam int DW   = REG_DATA_WIDTH;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 we3;
    logic [AW-1:0]        a3;
    logic [DW-1:0]        wd3;
    logic [AW-1:0]        ra1, ra2;
    logic [DW-1:0]        rf_rd1, rf_rd2;
    logic [DW-1:0]        rd1, rd2;

    logic [AW-1:0]        v_addr [NREQ];
    logic [DW-1:0]        v_data [NREQ];

    int                   n_vec;
    int                   n_err;
    int                   m_ptr;
    logic [AW-1:0]        m_a;
    logic [DW-1:0]        m_d;
    int                   last_gnt;
    logic [NREQ-1:0]      last_ready;
    wb_write_t            sb [$];

    regfile_wb_arbiter #(
        .NREQ       (NREQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3),
        .ra1       (ra1),
        .ra2       (ra2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .rd1       (rd1),
        .rd2       (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = v_addr[i];
            req_data[i*DW +: DW] = v_data[i];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_ptr = 0;
        m_a   = '0;
        m_d   = '0;
        sb.delete();
    endtask

    // One clock: predict/compare ready at negedge, push expected write, pop/compare after posedge
    task automatic step();
        logic [NREQ-1:0] exp_ready;
        wb_write_t       e;
        wb_write_t       o;
        int              g;
        @(negedge clk);
        g = -1;
        if (rst_n && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        n_vec++;
        if (req_ready !== exp_ready) begin
            n_err++;
            $display("FAIL ready @%0t: got %b expected %b", $time, req_ready, exp_ready);
        end
        e.we = 1'b0;
        if (g >= 0) begin
            m_a   = v_addr[g];
            m_d   = v_data[g];
            e.we  = (v_addr[g] != REG_ZERO);
            m_ptr = (g + 1) % NREQ;
        end
        e.addr = m_a;
        e.data = m_d;
        sb.push_back(e);
        last_gnt   = g;
        last_ready = req_ready;
        @(posedge clk);
        #1;
        o = sb.pop_front();
        n_vec++;
        if (we3 !== o.we || a3 !== o.addr || wd3 !== o.data) begin
            n_err++;
            $display("FAIL wport @%0t: got we=%b a=%0d d=%h expected we=%b a=%0d d=%h",
                     $time, we3, a3, wd3, o.we, o.addr, o.data);
        end
    endtask

    // Step until every requester has been served; a requester drops valid once granted
    task automatic drain();
        int budget;
        budget = 0;
        while (req_valid != '0 && budget < 20) begin
            step();
            if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
            budget++;
        end
        n_vec++;
        if (req_valid != '0) begin
            n_err++;
            $display("FAIL drain_timeout: valid still %b after %0d cycles", req_valid, budget);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '1;
        v_addr[0] = 5'd3;  v_data[0] = 32'h0000_0003;
        v_addr[1] = 5'd4;  v_data[1] = 32'h0000_0004;
        v_addr[2] = 5'd6;  v_data[2] = 32'h0000_0006;
        ra1 = '0; ra2 = '0; rf_rd1 = '0; rf_rd2 = '0;
        model_reset();
        #12;
        n_vec++;
        if (req_ready !== 3'b000 || we3 !== 1'b0 || a3 !== '0 || wd3 !== '0) begin
            n_err++;
            $display("FAIL reset_state: ready=%b we=%b a=%0d d=%h expected 000/0/0/0",
                     req_ready, we3, a3, wd3);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        n_vec++;
        if (last_ready !== 3'b001) begin
            n_err++;
            $display("FAIL reset_first_grant: ready=%b expected 001", last_ready);
        end
        req_valid[last_gnt >= 0 ? last_gnt : 0] = 1'b0;
        drain();
    endtask

    task automatic test_fairness();
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            v_addr[i] = AW'(10 + i);
            v_data[i] = 32'hA000_0000 + i;
        end
        for (int c = 0; c < 6; c++) begin
            step();
            n_vec++;
            if (last_gnt != c % NREQ) begin
                n_err++;
                $display("FAIL fairness_order: cycle %0d grant %0d expected %0d", c, last_gnt, c % NREQ);
            end
            if (last_gnt >= 0) begin
                v_addr[last_gnt] = v_addr[last_gnt] + AW'(3);
                v_data[last_gnt] = $urandom;
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_single_write();
        req_valid = 3'b000;
        req_valid[REQ_LOAD] = 1'b1;
        v_addr[REQ_LOAD] = 5'd5;
        v_data[REQ_LOAD] = 32'hDEADBEEF;
        step();
        req_valid = '0;
        n_vec++;
        if (last_ready !== 3'b010 || we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL single_write: ready=%b we=%b a=%0d d=%h expected 010/1/5/deadbeef",
                     last_ready, we3, a3, wd3);
        end
        step();
    endtask

    task automatic test_x0();
        req_valid = 3'b000;
        req_valid[REQ_CSR] = 1'b1;
        v_addr[REQ_CSR] = REG_ZERO;
        v_data[REQ_CSR] = 32'h1234;
        step();
        req_valid = '0;
        n_vec++;
        if (last_ready !== 3'b100 || we3 !== 1'b0) begin
            n_err++;
            $display("FAIL x0_suppress: ready=%b we=%b expected 100/0", last_ready, we3);
        end
        req_valid = '1;
        v_addr[0] = 5'd1; v_addr[1] = 5'd2; v_addr[2] = 5'd3;
        step();
        n_vec++;
        if (last_ready !== 3'b001) begin
            n_err++;
            $display("FAIL x0_ptr_wrap: ready=%b expected 001", last_ready);
        end
        if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
        drain();
    endtask

    task automatic test_flush_reset();
        flush     = 1'b1;
        req_valid = 3'b011;
        v_addr[0] = 5'd8; v_data[0] = 32'h0808_0808;
        v_addr[1] = 5'd9; v_data[1] = 32'h0909_0909;
        step();
        n_vec++;
        if (last_ready !== 3'b000 || we3 !== 1'b0) begin
            n_err++;
            $display("FAIL flush: ready=%b we=%b expected 000/0", last_ready, we3);
        end
        flush = 1'b0;
        step();
        if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
        n_vec++;
        if (we3 !== 1'b1 || a3 !== 5'd8) begin
            n_err++;
            $display("FAIL post_flush_write: we=%b a=%0d expected 1/8", we3, a3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (we3 !== 1'b0 || a3 !== '0 || wd3 !== '0 || req_ready !== '0) begin
            n_err++;
            $display("FAIL async_reset: we=%b a=%0d d=%h ready=%b expected 0/0/0/000",
                     we3, a3, wd3, req_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        n_vec++;
        if (last_ready !== 3'b010) begin
            n_err++;
            $display("FAIL rearb_after_reset: ready=%b expected 010", last_ready);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_rd1;
        req_valid = 3'b000;
        req_valid[REQ_ALU] = 1'b1;
        v_addr[REQ_ALU] = 5'd7;
        v_data[REQ_ALU] = 32'hCAFE0001;
        step();
        req_valid = '0;
        ra1 = 5'd7; rf_rd1 = 32'h0;
        ra2 = 5'd0; rf_rd2 = 32'h0000_0055;
        #1;
`ifdef WB_ARB_BYPASS_EN
        exp_rd1 = 32'hCAFE0001;
`else
        exp_rd1 = 32'h0;
`endif
        n_vec++;
        if (rd1 !== exp_rd1) begin
            n_err++;
            $display("FAIL bypass_rd1_hit: got %h expected %h", rd1, exp_rd1);
        end
        n_vec++;
        if (rd2 !== 32'h0000_0055) begin
            n_err++;
            $display("FAIL bypass_rd2_x0: got %h expected 00000055", rd2);
        end
        ra1 = 5'd8; rf_rd1 = 32'h0000_0011;
        #1;
        n_vec++;
        if (rd1 !== 32'h0000_0011) begin
            n_err++;
            $display("FAIL bypass_rd1_miss: got %h expected 00000011", rd1);
        end
        req_valid[REQ_ALU] = 1'b1;
        v_addr[REQ_ALU] = REG_ZERO;
        v_data[REQ_ALU] = 32'h7777_7777;
        step();
        req_valid = '0;
        ra1 = 5'd0; rf_rd1 = 32'h0000_0022;
        ra2 = 5'd0; rf_rd2 = 32'h0000_0099;
        #1;
        n_vec++;
        if (rd1 !== 32'h0000_0022 || rd2 !== 32'h0000_0099) begin
            n_err++;
            $display("FAIL bypass_a3_zero: rd1=%h rd2=%h expected 00000022/00000099", rd1, rd2);
        end
        step();
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        last_gnt = -1;
        test_reset();
        test_fairness();
        test_single_write();
        test_x0();
        test_flush_reset();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
